sos_controller: RTL and testbench
=================================

Name: sos_controller

Overview:
Parametrised multi-source emergency handler for the elevator controller. It takes N_CH raw SOS sources, such as the cabin button, door-jam sensor and overload sensor, and synchronises and debounces each one. The sources are merged into a single latched emergency state with an acknowledge and clear handshake. It drives the sos_mode line consumed by the floor/motion FSM, plus an operator alarm and a report of which source fired.

Parameters:
N_CH, 4, number of SOS sources (1..16)
DEBOUNCE, 4, cycles a synchronised input must stay stable before its debounced level changes (>=1)
COUNT_W, 8, width of saturating event counter
BEACON_HALF, 8, half-period in cycles of beacon blink (used only with SOS_BEACON_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
sos_req  in  N_CH  raw SOS sources, asynchronous, active-high
ack  in  1  operator acknowledge pulse (silences alarm)
clear  in  1  operator clear pulse (leaves emergency)
sos_mode  out  1  1 while in ALARM or HELD
alarm_out  out  1  1 only in ALARM
beacon  out  1  blink indicator
active_ch  out  CH_W  lowest-index pending channel; 0 when none pending
pending  out  N_CH  per-channel latched press flags
event_count  out  COUNT_W  total press events, saturating

Behaviour:
- CH_W = max(1, clog2(N_CH)).
- Reset (rst=1 at clk edge): all outputs 0, including beacon. FSM goes to IDLE. Sync flops, debounce counters and debounced levels go to 0. Reset takes effect from any state, mid-debounce included.
- Per channel: 2-flop synchroniser, then debounce.
  - Debounce counter increments while the synced value differs from the debounced level. It resets to 0 when they match.
  - When the counter reaches DEBOUNCE the debounced level takes the synced value.
  - A press event is a 1-cycle pulse on a debounced 0->1 transition.
- Latency: a sos_req bit held high from before edge k gives sos_mode=1 after edge k+DEBOUNCE+3. Glitches shorter than DEBOUNCE cycles produce no event.
- pending[i] is set on a press event on channel i and cleared only by IDLE entry or rst.
- event_count increments by the number of press events in the cycle (popcount) and saturates at all-ones.
- FSM states are IDLE, ALARM and HELD. Priority within a cycle: rst > press event > ack > clear.
  - IDLE: on any press event, go to ALARM.
  - ALARM: a press event keeps ALARM. On ack with no press event, go to HELD. clear is ignored in ALARM.
  - HELD: on a press event, go back to ALARM. On clear with no press event and every debounced level 0, go to IDLE. clear is ignored while any debounced level is 1.
- IDLE entry clears pending in the same edge.
- sos_mode, alarm_out, active_ch and pending are registered and reflect the state after the edge.
- active_ch is a priority encode of pending, lowest index wins. It is 0 when pending is 0.
- ack or clear in IDLE: no effect.

Optional Feature:
SOS_BEACON_EN
- Defined:
  - beacon toggles every BEACON_HALF cycles while in ALARM, starting at 1 on ALARM entry.
  - beacon is forced to 0 outside ALARM, and the blink counter resets on ALARM exit.
- Undefined: beacon = alarm_out, and no blink counter is synthesised.

Decomposition:
- Shared package sos_pkg holds:
  - state encoding constants SOS_IDLE=2'd0, SOS_ALARM=2'd1, SOS_HELD=2'd2;
  - a clog2-style CH_W helper function.
- One sub-module, sos_debouncer: single channel, parameter DEBOUNCE. Ports are clk, rst, din, level, rise. It contains the synchroniser, debounce counter and edge pulse, and is instantiated N_CH times via generate.

Test Plan:
All scenarios use N_CH=4, DEBOUNCE=4.
1. Reset, then sos_req=4'b0100 held -> sos_mode=1 after exactly 7 edges, alarm_out=1, active_ch=2, pending=4'b0100, event_count=1.
2. sos_req[0] pulsed high for 3 cycles -> no event: sos_mode stays 0, event_count=0.
3. In ALARM, pulse ack -> HELD (alarm_out=0, sos_mode=1). Pulse clear while sos_req[2] still high -> stays HELD. Drop sos_req[2], wait 7 cycles, pulse clear -> IDLE, pending=0, active_ch=0.
4. In HELD, a new press on channel 1 arrives in the same cycle as clear -> ALARM, pending=4'b0110, active_ch=1, event_count=2.
5. Channels 0 and 3 pressed in the same cycle -> event_count +2, active_ch=0. Drive 300 events with COUNT_W=8 -> event_count saturates at 255.
6. Assert rst mid-debounce and again in ALARM -> all outputs 0 next edge. With SOS_BEACON_EN, BEACON_HALF=8: beacon reads 1,0,1 over 24 ALARM cycles and is 0 in HELD.

Source files
------------

// File: rtl/sos_pkg.sv
// Shared state encoding and width helper for the elevator SOS controller.
package sos_pkg;

    localparam logic [1:0] SOS_IDLE  = 2'd0;
    localparam logic [1:0] SOS_ALARM = 2'd1;
    localparam logic [1:0] SOS_HELD  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = SOS_IDLE,
        ST_ALARM = SOS_ALARM,
        ST_HELD  = SOS_HELD
    } sos_state_t;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/sos_debouncer.sv
// One SOS source: 2-flop synchroniser, stability counter and registered rise pulse.
module sos_debouncer
    import sos_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int unsigned      CNT_W    = ch_width(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    // Level only follows the synced input after DEBOUNCE consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= din;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/sos_controller.sv
// Multi-source SOS handler: debounced sources latched into IDLE/ALARM/HELD with ack/clear.
// Optional blinking beacon enabled by defining SOS_BEACON_EN.
module sos_controller
    import sos_pkg::*;
#(
    parameter  int unsigned N_CH        = 4,
    parameter  int unsigned DEBOUNCE    = 4,
    parameter  int unsigned COUNT_W     = 8,
    parameter  int unsigned BEACON_HALF = 8,
    localparam int unsigned CH_W        = ch_width(N_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    sos_req,
    input  logic               ack,
    input  logic               clear,
    output logic               sos_mode,
    output logic               alarm_out,
    output logic               beacon,
    output logic [CH_W-1:0]    active_ch,
    output logic [N_CH-1:0]    pending,
    output logic [COUNT_W-1:0] event_count
);

    localparam int unsigned PC_W  = ch_width(N_CH + 1);
    localparam int unsigned SUM_W = COUNT_W + PC_W;

    if (N_CH < 1 || N_CH > 16 || DEBOUNCE < 1 || BEACON_HALF < 1) begin : g_param_err
        $error("sos_controller: parameter out of range");
    end

    logic [N_CH-1:0]    w_level;
    logic [N_CH-1:0]    w_rise;
    logic               w_any_rise;
    logic               w_any_level;
    sos_state_t         r_state;
    sos_state_t         w_state_next;
    logic [N_CH-1:0]    w_pending_next;
    logic [CH_W-1:0]    w_active_next;
    logic [PC_W-1:0]    w_pop;
    logic [SUM_W-1:0]   w_sum;
    logic [COUNT_W-1:0] w_count_next;
    logic               r_mode;
    logic               r_alarm;
    logic [CH_W-1:0]    r_active;
    logic [N_CH-1:0]    r_pending;
    logic [COUNT_W-1:0] r_count;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sos_debouncer #(.DEBOUNCE(DEBOUNCE)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .din   (sos_req[i]),
            .level (w_level[i]),
            .rise  (w_rise[i])
        );
    end

    assign w_any_rise  = |w_rise;
    assign w_any_level = |w_level;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Press beats ack beats clear; clear only leaves HELD once every source is released.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_rise) w_state_next = ST_ALARM;
            ST_ALARM: if (!w_any_rise && ack) w_state_next = ST_HELD;
            ST_HELD: begin
                if (w_any_rise)                  w_state_next = ST_ALARM;
                else if (clear && !w_any_level)  w_state_next = ST_IDLE;
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pending_next = (w_state_next == ST_IDLE) ? '0 : (r_pending | w_rise);
        w_active_next  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_pending_next[i]) w_active_next = CH_W'(i);
        end
    end

    // Saturating add of this cycle's press count.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_pop = w_pop + PC_W'(w_rise[i]);
        end
        w_sum        = SUM_W'(r_count) + SUM_W'(w_pop);
        w_count_next = (w_sum > SUM_W'({COUNT_W{1'b1}})) ? {COUNT_W{1'b1}}
                                                        : w_sum[COUNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode    <= 1'b0;
            r_alarm   <= 1'b0;
            r_active  <= '0;
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            r_mode    <= (w_state_next != ST_IDLE);
            r_alarm   <= (w_state_next == ST_ALARM);
            r_active  <= w_active_next;
            r_pending <= w_pending_next;
            r_count   <= w_count_next;
        end
    end

`ifdef SOS_BEACON_EN
    localparam int unsigned BL_W = ch_width(BEACON_HALF);

    logic [BL_W-1:0] r_blink_cnt;
    logic            r_beacon;

    // Blink restarts high on every ALARM entry and is held dark elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_beacon    <= 1'b0;
        end else if (w_state_next != ST_ALARM) begin
            r_blink_cnt <= '0;
            r_beacon    <= 1'b0;
        end else if (r_state != ST_ALARM) begin
            r_blink_cnt <= '0;
            r_beacon    <= 1'b1;
        end else if (r_blink_cnt == BL_W'(BEACON_HALF - 1)) begin
            r_blink_cnt <= '0;
            r_beacon    <= ~r_beacon;
        end else begin
            r_blink_cnt <= r_blink_cnt + BL_W'(1);
        end
    end

    assign beacon = r_beacon;
`else
    assign beacon = r_alarm;
`endif

    assign sos_mode    = r_mode;
    assign alarm_out   = r_alarm;
    assign active_ch   = r_active;
    assign pending     = r_pending;
    assign event_count = r_count;

endmodule

// File: tb/tb_sos_controller.sv
// Scoreboard bench for sos_controller: expected output changes queued with their edge number.
module tb_sos_controller;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [3:0] sos_req = 4'b0000;
    logic       ack     = 1'b0;
    logic       clear   = 1'b0;
    logic       sos_mode;
    logic       alarm_out;
    logic       beacon;
    logic [1:0] active_ch;
    logic [3:0] pending;
    logic [7:0] event_count;

    sos_controller #(
        .N_CH        (4),
        .DEBOUNCE    (4),
        .COUNT_W     (8),
        .BEACON_HALF (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sos_req     (sos_req),
        .ack         (ack),
        .clear       (clear),
        .sos_mode    (sos_mode),
        .alarm_out   (alarm_out),
        .beacon      (beacon),
        .active_ch   (active_ch),
        .pending     (pending),
        .event_count (event_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [16:0] snap;
    } exp_t;

    exp_t        q[$];
    int          tests  = 0;
    int          fails  = 0;
    bit          mon_en = 1'b0;
    bit          first  = 1'b1;
    logic [16:0] last   = '0;

    function automatic logic [16:0] mk(input bit m, input bit a, input logic [1:0] act,
                                       input logic [3:0] pend, input logic [7:0] cnt);
`ifdef SOS_BEACON_EN
        return {m, a, 1'b0, act, pend, cnt};
`else
        return {m, a, a, act, pend, cnt};
`endif
    endfunction

    function automatic logic [16:0] cur_snap();
`ifdef SOS_BEACON_EN
        return {sos_mode, alarm_out, 1'b0, active_ch, pending, event_count};
`else
        return {sos_mode, alarm_out, beacon, active_ch, pending, event_count};
`endif
    endfunction

    task automatic expect_at(input int d, input logic [16:0] s);
        exp_t e;
        e.cyc  = cyc + d;
        e.snap = s;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every change of the output bundle must match the head of the queue, at the queued edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [16:0] cur;
            cur = cur_snap();
            if (first || cur !== last) begin
                first = 1'b0;
                last  = cur;
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (cur !== e.snap || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL output_event cyc=%0d got=%h required=%h at cyc %0d",
                                 cyc, cur, e.snap, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog timeout cyc=%0d required=finish", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int mcnt;
        int nxt;

        // Reset state
        tick(3);
        rst    = 1'b0;
        mon_en = 1'b1;
        expect_at(0, mk(0, 0, 2'd0, 4'b0000, 8'd0));

        // Three-cycle glitch on channel 0: no event
        tick(2);
        sos_req = 4'b0001;
        tick(3);
        sos_req = 4'b0000;
        tick(12);

        // Held press on channel 2: ALARM exactly 8 edges after driving (k+7)
        sos_req = 4'b0100;
        expect_at(8, mk(1, 1, 2'd2, 4'b0100, 8'd1));
        tick(12);

        // ack -> HELD; clear ignored while channel 2 still debounced high
        ack = 1'b1;
        expect_at(1, mk(1, 0, 2'd2, 4'b0100, 8'd1));
        tick(1);
        ack = 1'b0;
        tick(2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(2);

        // Channel 1 press lands in the same cycle as clear -> back to ALARM
        sos_req = 4'b0110;
        tick(7);
        clear = 1'b1;
        expect_at(1, mk(1, 1, 2'd1, 4'b0110, 8'd2));
        tick(1);
        clear = 1'b0;
        tick(3);

        // ack, release all, wait 7 cycles, clear -> IDLE with pending cleared
        ack = 1'b1;
        expect_at(1, mk(1, 0, 2'd1, 4'b0110, 8'd2));
        tick(1);
        ack = 1'b0;
        tick(2);
        sos_req = 4'b0000;
        tick(7);
        clear = 1'b1;
        expect_at(1, mk(0, 0, 2'd0, 4'b0000, 8'd2));
        tick(1);
        clear = 1'b0;
        tick(3);

        // ack/clear in IDLE have no effect
        ack   = 1'b1;
        clear = 1'b1;
        tick(1);
        ack   = 1'b0;
        clear = 1'b0;
        tick(3);

        // Channels 0 and 3 together: +2 events, lowest index reported
        sos_req = 4'b1001;
        expect_at(8, mk(1, 1, 2'd0, 4'b1001, 8'd4));
        tick(10);
        sos_req = 4'b0000;
        tick(8);

        // 300 more events on all four channels: counter saturates at 255
        mcnt = 4;
        for (int i = 0; i < 75; i++) begin
            nxt = (mcnt + 4 > 255) ? 255 : mcnt + 4;
            sos_req = 4'b1111;
            if (nxt != mcnt) expect_at(8, mk(1, 1, 2'd0, 4'b1111, 8'(nxt)));
            mcnt = nxt;
            tick(8);
            sos_req = 4'b0000;
            tick(8);
        end

        // Reset in ALARM clears everything on the next edge
        rst = 1'b1;
        expect_at(1, mk(0, 0, 2'd0, 4'b0000, 8'd0));
        tick(1);
        rst = 1'b0;

        // Reset mid-debounce restarts the debounce from scratch
        tick(2);
        sos_req = 4'b0001;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_at(8, mk(1, 1, 2'd0, 4'b0001, 8'd1));
        tick(10);
        rst = 1'b1;
        expect_at(1, mk(0, 0, 2'd0, 4'b0000, 8'd0));
        tick(1);
        rst     = 1'b0;
        sos_req = 4'b0000;
        tick(10);

`ifdef SOS_BEACON_EN
        // Beacon: 8 high, 8 low, 8 high in ALARM, then dark in HELD
        sos_req = 4'b0001;
        expect_at(8, mk(1, 1, 2'd0, 4'b0001, 8'd1));
        tick(8);
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            tests++;
            if (beacon !== ((j / 8) % 2 == 0)) begin
                fails++;
                $display("FAIL beacon_blink j=%0d got=%b required=%b", j, beacon, ((j / 8) % 2 == 0));
            end
        end
        @(posedge clk);
        #1;
        ack = 1'b1;
        expect_at(1, mk(1, 0, 2'd0, 4'b0001, 8'd1));
        tick(1);
        ack = 1'b0;
        tick(2);
        @(negedge clk);
        tests++;
        if (beacon !== 1'b0) begin
            fails++;
            $display("FAIL beacon_held got=%b required=0", beacon);
        end
        tick(1);
`endif

        tick(5);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL missing_events got=%0d outstanding required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
